clock_enable_synth: RTL and testbench

- Parametrised multi-channel clock-enable synthesiser running entirely in the `refclk` domain.
- Each channel is a phase accumulator (DDS-style) producing a one-cycle `tick` enable and a ~50% duty `level` square wave, both at a programmable fractional rate of refclk.
- Adds over the fixed single-output PLL wrapper: runtime rate/phase reprogramming, channel count, per-channel gating, and a deterministic lock indication.
- Sits beside the system PLL; feeds clock enables to downstream logic so that no extra clock domains are created.

---
 rtl/clock_enable_synth.sv | 148 ++++++++++++++
 tb/tb_clock_enable_synth.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_synth.sv
// Multi-channel DDS clock-enable synthesiser: each channel is a phase accumulator
// that emits a one-cycle tick on wrap and a square-wave level from its MSB.
module clock_enable_synth #(
   parameter int               NUM_CH      = 4,
   parameter int               ACC_W       = 32,
   parameter int               LOCK_CYCLES = 16,
   parameter logic [ACC_W-1:0] DEFAULT_INC = '0,
   parameter int               CH_W        = (($clog2(NUM_CH + 1) < 1) ? 1 : $clog2(NUM_CH + 1))
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] chan_en,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   input  logic [ACC_W-1:0]  cfg_phase,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] level,
   output logic              locked
);

   localparam int              CNT_W    = (($clog2(LOCK_CYCLES + 1) < 1) ? 1 : $clog2(LOCK_CYCLES + 1));
   localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);
   localparam logic [CH_W-1:0]  CH_LIMIT = CH_W'(NUM_CH);

   // Accumulator add with the wrap carry kept as the top bit.
   function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   logic [ACC_W-1:0]  acc_r      [NUM_CH];
   logic [ACC_W-1:0]  inc_r      [NUM_CH];
   logic [ACC_W-1:0]  acc_nxt_s  [NUM_CH];
   logic [ACC_W-1:0]  inc_nxt_s  [NUM_CH];
   logic [ACC_W:0]    sum_s      [NUM_CH];
   logic [NUM_CH-1:0] tick_r;
   logic [NUM_CH-1:0] tick_nxt_s;
   logic [NUM_CH-1:0] level_s;
   logic [NUM_CH-1:0] chan_en_q_r;
   logic              cfg_valid_s;
   logic              cfg_invalid_s;
   logic              cfg_err_r;
   logic              init_r;
   logic              disturb_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic              locked_r;

   // Classify the configuration write as in-range or out-of-range.
   always_comb begin
      cfg_valid_s   = 1'b0;
      cfg_invalid_s = 1'b0;
      if (cfg_we) begin
         if (cfg_ch < CH_LIMIT) begin
            cfg_valid_s = 1'b1;
         end else begin
            cfg_invalid_s = 1'b1;
         end
      end else begin
         cfg_valid_s   = 1'b0;
         cfg_invalid_s = 1'b0;
      end
   end

   // Per-channel next state: a write beats the accumulate, gating freezes the phase.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         sum_s[c]      = acc_add(acc_r[c], inc_r[c]);
         acc_nxt_s[c]  = acc_r[c];
         inc_nxt_s[c]  = inc_r[c];
         tick_nxt_s[c] = 1'b0;
         if (cfg_valid_s && (cfg_ch == CH_W'(c))) begin
            acc_nxt_s[c]  = cfg_phase;
            inc_nxt_s[c]  = cfg_inc;
            tick_nxt_s[c] = 1'b0;
         end else if (chan_en[c]) begin
            acc_nxt_s[c]  = sum_s[c][ACC_W-1:0];
            tick_nxt_s[c] = sum_s[c][ACC_W];
         end else begin
            acc_nxt_s[c]  = acc_r[c];
            tick_nxt_s[c] = 1'b0;
         end
      end
   end

   // The first edge out of reset always restarts the count, so lock latency
   // does not depend on the chan_en value present during reset.
   always_comb begin
      disturb_s = init_r | cfg_valid_s | (chan_en != chan_en_q_r);
      cnt_nxt_s = cnt_r;
      if (disturb_s) begin
         cnt_nxt_s = '0;
      end else if (cnt_r < LOCK_MAX) begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Channel accumulators, increments and registered tick enables.
   always_ff @(posedge refclk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            acc_r[c] <= '0;
            inc_r[c] <= DEFAULT_INC;
         end
         tick_r <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            acc_r[c] <= acc_nxt_s[c];
            inc_r[c] <= inc_nxt_s[c];
         end
         tick_r <= tick_nxt_s;
      end
   end

   // Lock counter, lock flag, error pulse and the previous-cycle enable snapshot.
   always_ff @(posedge refclk) begin
      if (rst) begin
         cnt_r       <= '0;
         locked_r    <= 1'b0;
         cfg_err_r   <= 1'b0;
         chan_en_q_r <= '0;
         init_r      <= 1'b1;
      end else begin
         cnt_r       <= cnt_nxt_s;
         locked_r    <= (cnt_nxt_s == LOCK_MAX);
         cfg_err_r   <= cfg_invalid_s;
         chan_en_q_r <= chan_en;
         init_r      <= 1'b0;
      end
   end

   // Level is the accumulator MSB taken straight from the register.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         level_s[c] = acc_r[c][ACC_W-1];
      end
   end

   assign tick    = tick_r;
   assign level   = level_s;
   assign locked  = locked_r;
   assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_clock_enable_synth.sv
// Directed self-checking bench for clock_enable_synth at default parameters
// (NUM_CH=4, ACC_W=32, LOCK_CYCLES=16, DEFAULT_INC=0).
module tb_clock_enable_synth;

   logic        refclk;
   logic        rst;
   logic [3:0]  chan_en;
   logic        cfg_we;
   logic [2:0]  cfg_ch;
   logic [31:0] cfg_inc;
   logic [31:0] cfg_phase;
   logic        cfg_err;
   logic [3:0]  tick;
   logic [3:0]  level;
   logic        locked;

   int checks;
   int failures;

   clock_enable_synth #(
      .NUM_CH      (4),
      .ACC_W       (32),
      .LOCK_CYCLES (16),
      .DEFAULT_INC (32'h0000_0000)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .chan_en   (chan_en),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_inc   (cfg_inc),
      .cfg_phase (cfg_phase),
      .cfg_err   (cfg_err),
      .tick      (tick),
      .level     (level),
      .locked    (locked)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge refclk);
      #1;
   endtask

   task automatic do_write(input logic [2:0] ch, input logic [31:0] inc, input logic [31:0] ph);
      cfg_we    = 1'b1;
      cfg_ch    = ch;
      cfg_inc   = inc;
      cfg_phase = ph;
      step();
      cfg_we    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; chan_en = 4'hF; cfg_we = 1'b0; cfg_ch = 3'd0;
      cfg_inc = 32'h0; cfg_phase = 32'h0;
      step(); step();
      checks++; if (tick !== 4'b0000) begin failures++; $display("FAIL reset_tick got=%b exp=0000", tick); end
      checks++; if (level !== 4'b0000) begin failures++; $display("FAIL reset_level got=%b exp=0000", level); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
      rst = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         step();
         checks++; if ((tick !== 4'b0000) || (level !== 4'b0000)) begin
            failures++; $display("FAIL idle_out edge=%0d tick=%b level=%b exp=0000", i, tick, level);
         end
         checks++; if (locked !== (i == 17)) begin
            failures++; $display("FAIL lock_rise edge=%0d got=%b exp=%b", i, locked, (i == 17));
         end
      end
   endtask

   task automatic test_quarter();
      do_write(3'd0, 32'h4000_0000, 32'h0000_0000);
      for (int i = 1; i <= 12; i++) begin
         step();
         checks++; if (tick[0] !== ((i % 4) == 0)) begin
            failures++; $display("FAIL quarter_tick k=%0d got=%b exp=%b", i, tick[0], ((i % 4) == 0));
         end
         checks++; if (level[0] !== (((i % 4) == 2) || ((i % 4) == 3))) begin
            failures++; $display("FAIL quarter_level k=%0d got=%b exp=%b", i, level[0], (((i % 4) == 2) || ((i % 4) == 3)));
         end
      end
   endtask

   task automatic test_back_to_back();
      do_write(3'd1, 32'h8000_0000, 32'h0000_0000);
      for (int i = 1; i <= 8; i++) begin
         step();
         checks++; if (level[1] !== ((i % 2) == 1)) begin
            failures++; $display("FAIL half_level k=%0d got=%b exp=%b", i, level[1], ((i % 2) == 1));
         end
         checks++; if (tick[1] !== ((i % 2) == 0)) begin
            failures++; $display("FAIL half_tick k=%0d got=%b exp=%b", i, tick[1], ((i % 2) == 0));
         end
      end
      do_write(3'd1, 32'hFFFF_FFFF, 32'h0000_0000);
      for (int i = 1; i <= 8; i++) begin
         step();
         checks++; if (tick[1] !== (i >= 2)) begin
            failures++; $display("FAIL max_tick k=%0d got=%b exp=%b", i, tick[1], (i >= 2));
         end
         checks++; if (level[1] !== 1'b1) begin
            failures++; $display("FAIL max_level k=%0d got=%b exp=1", i, level[1]);
         end
      end
   endtask

   task automatic test_fractional();
      int cnt;
      int last;
      int bad;
      cnt = 0; last = 0; bad = 0;
      do_write(3'd2, 32'h5555_5556, 32'h0000_0000);
      for (int i = 1; i <= 300; i++) begin
         step();
         if (tick[2] === 1'b1) begin
            cnt++;
            if ((i - last) != 3) bad++;
            last = i;
         end
      end
      checks++; if (cnt != 100) begin failures++; $display("FAIL frac_count got=%0d exp=100", cnt); end
      checks++; if (bad != 0) begin failures++; $display("FAIL frac_spacing bad_gaps=%0d exp=0", bad); end
   endtask

   task automatic test_phase();
      // ch3 is held while ch0 is written so both start from the same edge.
      do_write(3'd3, 32'h4000_0000, 32'h8000_0000);
      chan_en = 4'b0111;
      do_write(3'd0, 32'h4000_0000, 32'h0000_0000);
      chan_en = 4'hF;
      for (int i = 1; i <= 20; i++) begin
         step();
         checks++; if ((tick[0] !== ((i % 4) == 0)) || (tick[3] !== ((i % 4) == 2))) begin
            failures++; $display("FAIL phase_tick k=%0d got=%b%b exp=%b%b", i, tick[3], tick[0], ((i % 4) == 2), ((i % 4) == 0));
         end
         checks++; if (level[3] !== (((i % 4) == 0) || ((i % 4) == 1))) begin
            failures++; $display("FAIL phase_level3 k=%0d got=%b exp=%b", i, level[3], (((i % 4) == 0) || ((i % 4) == 1)));
         end
         if ((i == 16) || (i == 17)) begin
            checks++; if (locked !== (i == 17)) begin
               failures++; $display("FAIL relock_write k=%0d got=%b exp=%b", i, locked, (i == 17));
            end
         end
      end
      chan_en = 4'b0111;
      for (int i = 21; i <= 25; i++) begin
         step();
         checks++; if ((tick[3] !== 1'b0) || (tick[0] !== ((i % 4) == 0))) begin
            failures++; $display("FAIL gated_tick k=%0d got=%b%b exp=0%b", i, tick[3], tick[0], ((i % 4) == 0));
         end
         if (i == 21) begin
            checks++; if (locked !== 1'b0) begin failures++; $display("FAIL gate_unlock got=%b exp=0", locked); end
         end
      end
      chan_en = 4'hF;
      for (int i = 26; i <= 42; i++) begin
         step();
         checks++; if ((tick[0] !== ((i % 4) == 0)) || (tick[3] !== ((i % 4) == 3))) begin
            failures++; $display("FAIL shifted_tick k=%0d got=%b%b exp=%b%b", i, tick[3], tick[0], ((i % 4) == 3), ((i % 4) == 0));
         end
         checks++; if (level[3] !== (((i % 4) == 1) || ((i % 4) == 2))) begin
            failures++; $display("FAIL shifted_level3 k=%0d got=%b exp=%b", i, level[3], (((i % 4) == 1) || ((i % 4) == 2)));
         end
         if ((i == 41) || (i == 42)) begin
            checks++; if (locked !== (i == 42)) begin
               failures++; $display("FAIL relock_en k=%0d got=%b exp=%b", i, locked, (i == 42));
            end
         end
      end
   endtask

   task automatic test_invalid();
      for (int i = 43; i <= 48; i++) begin
         cfg_we    = ((i == 43) || (i == 45));
         cfg_ch    = (i == 43) ? 3'd4 : 3'd7;
         cfg_inc   = 32'h1234_5678;
         cfg_phase = 32'h0000_0000;
         step();
         checks++; if (cfg_err !== ((i == 43) || (i == 45))) begin
            failures++; $display("FAIL cfg_err k=%0d got=%b exp=%b", i, cfg_err, ((i == 43) || (i == 45)));
         end
         checks++; if (locked !== 1'b1) begin
            failures++; $display("FAIL invalid_locked k=%0d got=%b exp=1", i, locked);
         end
         checks++; if ((tick[0] !== ((i % 4) == 0)) || (tick[3] !== ((i % 4) == 3))) begin
            failures++; $display("FAIL invalid_tick k=%0d got=%b%b exp=%b%b", i, tick[3], tick[0], ((i % 4) == 3), ((i % 4) == 0));
         end
      end
      cfg_we = 1'b0;
   endtask

   task automatic test_midreset();
      rst = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd5;
      step();
      checks++; if ((tick !== 4'b0000) || (level !== 4'b0000)) begin
         failures++; $display("FAIL midrst_out tick=%b level=%b exp=0000", tick, level);
      end
      checks++; if ((locked !== 1'b0) || (cfg_err !== 1'b0)) begin
         failures++; $display("FAIL midrst_flags locked=%b cfg_err=%b exp=0 0", locked, cfg_err);
      end
      cfg_ch = 3'd0; cfg_inc = 32'h8000_0000; cfg_phase = 32'h8000_0000;
      step();
      checks++; if (level !== 4'b0000) begin
         failures++; $display("FAIL rst_write_level got=%b exp=0000", level);
      end
      rst = 1'b0; cfg_we = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++; if ((tick !== 4'b0000) || (level !== 4'b0000) || (locked !== 1'b0)) begin
            failures++; $display("FAIL post_rst edge=%0d tick=%b level=%b locked=%b exp=0000 0000 0", i, tick, level, locked);
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_quarter();
      test_back_to_back();
      test_fractional();
      test_phase();
      test_invalid();
      test_midreset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
